// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - stage instruction/data bundle between decode and the hazard/forwarding unit
interface hazard_fwd_unit_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic [31:0]     instr_de;
   logic [31:0]     instr_exe;
   logic [31:0]     instr_acc;
   logic [31:0]     instr_wb;
   logic            valid_exe;
   logic            valid_acc;
   logic            valid_wb;
   logic [XLEN-1:0] rs1_data_de;
   logic [XLEN-1:0] rs2_data_de;
   logic [XLEN-1:0] alu_out_exe;
   logic [XLEN-1:0] pc_4_exe;
   logic [XLEN-1:0] alu_out_acc;
   logic [XLEN-1:0] pc_4_acc;
   logic [XLEN-1:0] dmem_out_acc;
   logic [XLEN-1:0] wb_data;
   logic            stall;
   logic            hazard;
   logic [1:0]      fwd_sel_a;
   logic [1:0]      fwd_sel_b;
   logic [XLEN-1:0] data_a_mgr;
   logic [XLEN-1:0] data_b_mgr;

   modport master (
      output flush, instr_de, instr_exe, instr_acc, instr_wb,
             valid_exe, valid_acc, valid_wb, rs1_data_de, rs2_data_de,
             alu_out_exe, pc_4_exe, alu_out_acc, pc_4_acc, dmem_out_acc, wb_data,
      input  stall, hazard, fwd_sel_a, fwd_sel_b, data_a_mgr, data_b_mgr
   );

   modport slave (
      input  flush, instr_de, instr_exe, instr_acc, instr_wb,
             valid_exe, valid_acc, valid_wb, rs1_data_de, rs2_data_de,
             alu_out_exe, pc_4_exe, alu_out_acc, pc_4_acc, dmem_out_acc, wb_data,
      output stall, hazard, fwd_sel_a, fwd_sel_b, data_a_mgr, data_b_mgr
   );
endinterface

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - RV32 operand forwarding and load-use stall manager
// Define HAZARD_PERF_EN to add saturating stall/forward event counters.
module hazard_fwd_unit #(
   parameter int XLEN     = 32,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 2
) (
   input  logic              clk,
   input  logic              rst,
   hazard_fwd_unit_if.slave  bus
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]       perf_stall_cycles,
   output logic [31:0]       perf_fwd_events
`endif
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {CLS_NONE, CLS_ALU, CLS_PC4, CLS_LOAD} wb_cls_e;
   typedef enum logic {S_IDLE, S_STALL} state_e;

   function automatic wb_cls_e wb_class(input logic [6:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_OPIMM, OPC_OP: return CLS_ALU;
         OPC_JAL, OPC_JALR:                     return CLS_PC4;
         OPC_LOAD:                              return CLS_LOAD;
         default:                               return CLS_NONE;
      endcase
   endfunction

   function automatic logic produces(input logic valid, input wb_cls_e cls,
                                     input logic [4:0] rd, input logic [4:0] rs);
      return valid && (cls != CLS_NONE) && (rd != 5'd0) && (rd == rs);
   endfunction

   function automatic logic [1:0] pick(input logic m_exe, input logic m_acc, input logic m_wb);
      if (m_exe)      return 2'd1;
      else if (m_acc) return 2'd2;
      else if (m_wb)  return 2'd3;
      else            return 2'd0;
   endfunction

   logic [6:0]       opc_de;
   logic [4:0]       rs1, rs2;
   logic             use_rs1, use_rs2;
   wb_cls_e          cls_exe, cls_acc, cls_wb;
   logic             m_exe_a, m_acc_a, m_wb_a, m_exe_b, m_acc_b, m_wb_b;
   logic [XLEN-1:0]  exe_val, acc_val;
   logic             exe_load_hit, acc_load_hit, lu;
   logic [CNT_W-1:0] lu_n;
   state_e           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             stall_fsm;
   logic             unused_bits;

   assign opc_de  = bus.instr_de[6:0];
   assign rs1     = bus.instr_de[19:15];
   assign rs2     = bus.instr_de[24:20];
   assign use_rs1 = !(opc_de == OPC_LUI || opc_de == OPC_AUIPC || opc_de == OPC_JAL);
   assign use_rs2 = (opc_de == OPC_OP) || (opc_de == OPC_STORE) || (opc_de == OPC_BRANCH);
   assign cls_exe = wb_class(bus.instr_exe[6:0]);
   assign cls_acc = wb_class(bus.instr_acc[6:0]);
   assign cls_wb  = wb_class(bus.instr_wb[6:0]);

   // Unused sources never match, so they cannot forward or stall.
   assign m_exe_a = use_rs1 && produces(bus.valid_exe, cls_exe, bus.instr_exe[11:7], rs1);
   assign m_acc_a = use_rs1 && produces(bus.valid_acc, cls_acc, bus.instr_acc[11:7], rs1);
   assign m_wb_a  = use_rs1 && produces(bus.valid_wb,  cls_wb,  bus.instr_wb[11:7],  rs1);
   assign m_exe_b = use_rs2 && produces(bus.valid_exe, cls_exe, bus.instr_exe[11:7], rs2);
   assign m_acc_b = use_rs2 && produces(bus.valid_acc, cls_acc, bus.instr_acc[11:7], rs2);
   assign m_wb_b  = use_rs2 && produces(bus.valid_wb,  cls_wb,  bus.instr_wb[11:7],  rs2);

   assign exe_val = (cls_exe == CLS_PC4) ? bus.pc_4_exe : bus.alu_out_exe;
   assign acc_val = (cls_acc == CLS_PC4)  ? bus.pc_4_acc :
                    (cls_acc == CLS_LOAD) ? bus.dmem_out_acc : bus.alu_out_acc;

   assign bus.fwd_sel_a = pick(m_exe_a, m_acc_a, m_wb_a);
   assign bus.fwd_sel_b = pick(m_exe_b, m_acc_b, m_wb_b);
   assign bus.hazard    = (bus.fwd_sel_a != 2'd0) || (bus.fwd_sel_b != 2'd0);

   always_comb begin
      case (bus.fwd_sel_a)
         2'd1:    bus.data_a_mgr = exe_val;
         2'd2:    bus.data_a_mgr = acc_val;
         2'd3:    bus.data_a_mgr = bus.wb_data;
         default: bus.data_a_mgr = bus.rs1_data_de;
      endcase
      case (bus.fwd_sel_b)
         2'd1:    bus.data_b_mgr = exe_val;
         2'd2:    bus.data_b_mgr = acc_val;
         2'd3:    bus.data_b_mgr = bus.wb_data;
         default: bus.data_b_mgr = bus.rs2_data_de;
      endcase
   end

   assign exe_load_hit = (cls_exe == CLS_LOAD) && (m_exe_a || m_exe_b);
   assign acc_load_hit = (LOAD_LAT == 2) && (cls_acc == CLS_LOAD) &&
                         ((m_acc_a && !m_exe_a) || (m_acc_b && !m_exe_b));
   assign lu           = exe_load_hit || acc_load_hit;
   assign lu_n         = exe_load_hit ? CNT_W'(LOAD_LAT) : CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      stall_fsm = 1'b0;
      case (state)
         S_IDLE: begin
            stall_fsm = lu;
            if (lu && (lu_n > CNT_W'(1))) begin
               cnt_nx   = lu_n - CNT_W'(1);
               state_nx = S_STALL;
            end
         end
         S_STALL: begin
            stall_fsm = 1'b1;
            cnt_nx    = cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      if (bus.flush) begin
         state_nx  = S_IDLE;
         cnt_nx    = '0;
         stall_fsm = 1'b0;
      end
   end

   // Gating with rst keeps stall low while reset is held even if lu is still true.
   assign bus.stall = stall_fsm && !rst;

   assign unused_bits = ^{bus.instr_de[31:25], bus.instr_de[14:7],
                          bus.instr_exe[31:12], bus.instr_acc[31:12], bus.instr_wb[31:12]};

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_stall_cycles <= '0;
         perf_fwd_events   <= '0;
      end else begin
         if (bus.stall && (perf_stall_cycles != 32'hFFFF_FFFF))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (bus.hazard && !bus.stall && (perf_fwd_events != 32'hFFFF_FFFF))
            perf_fwd_events <= perf_fwd_events + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - scoreboard bench for hazard_fwd_unit, LOAD_LAT=1 and LOAD_LAT=2 side by side
module tb_hazard_fwd_unit;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYS    = 7'b1110011;

   typedef struct packed {
      logic        stall;
      logic        chk;
      logic        hazard;
      logic [1:0]  sa;
      logic [1:0]  sb;
      logic [31:0] da;
      logic [31:0] db;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   logic [31:0] instr_de, instr_exe, instr_acc, instr_wb;
   logic valid_exe, valid_acc, valid_wb;
   logic [31:0] rs1_data_de, rs2_data_de, alu_out_exe, pc_4_exe;
   logic [31:0] alu_out_acc, pc_4_acc, dmem_out_acc, wb_data;

   exp_t q1[$];
   exp_t q2[$];
   int   left1 = 0;
   int   left2 = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [6:0] ops [10];

   always #5 clk = ~clk;

   hazard_fwd_unit_if #(.XLEN(32)) h1();
   hazard_fwd_unit_if #(.XLEN(32)) h2();

`ifdef HAZARD_PERF_EN
   logic [31:0] p1s, p1f, p2s, p2f;
   hazard_fwd_unit #(.XLEN(32), .LOAD_LAT(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .bus(h1.slave), .perf_stall_cycles(p1s), .perf_fwd_events(p1f));
   hazard_fwd_unit #(.XLEN(32), .LOAD_LAT(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .bus(h2.slave), .perf_stall_cycles(p2s), .perf_fwd_events(p2f));
`else
   hazard_fwd_unit #(.XLEN(32), .LOAD_LAT(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .bus(h1.slave));
   hazard_fwd_unit #(.XLEN(32), .LOAD_LAT(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .bus(h2.slave));
`endif

   always_comb begin
      h1.flush = flush;               h2.flush = flush;
      h1.instr_de = instr_de;         h2.instr_de = instr_de;
      h1.instr_exe = instr_exe;       h2.instr_exe = instr_exe;
      h1.instr_acc = instr_acc;       h2.instr_acc = instr_acc;
      h1.instr_wb = instr_wb;         h2.instr_wb = instr_wb;
      h1.valid_exe = valid_exe;       h2.valid_exe = valid_exe;
      h1.valid_acc = valid_acc;       h2.valid_acc = valid_acc;
      h1.valid_wb = valid_wb;         h2.valid_wb = valid_wb;
      h1.rs1_data_de = rs1_data_de;   h2.rs1_data_de = rs1_data_de;
      h1.rs2_data_de = rs2_data_de;   h2.rs2_data_de = rs2_data_de;
      h1.alu_out_exe = alu_out_exe;   h2.alu_out_exe = alu_out_exe;
      h1.pc_4_exe = pc_4_exe;         h2.pc_4_exe = pc_4_exe;
      h1.alu_out_acc = alu_out_acc;   h2.alu_out_acc = alu_out_acc;
      h1.pc_4_acc = pc_4_acc;         h2.pc_4_acc = pc_4_acc;
      h1.dmem_out_acc = dmem_out_acc; h2.dmem_out_acc = dmem_out_acc;
      h1.wb_data = wb_data;           h2.wb_data = wb_data;
   end

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] ra, input logic [4:0] rb);
      return {7'b0, rb, ra, 3'b0, rd, op};
   endfunction

   // 0 = none, 1 = alu, 2 = pc+4, 3 = load
   function automatic int cls(input logic [6:0] op);
      if (op == OP_LUI || op == OP_AUIPC || op == OP_OPIMM || op == OP_OP) return 1;
      if (op == OP_JAL || op == OP_JALR) return 2;
      if (op == OP_LOAD) return 3;
      return 0;
   endfunction

   function automatic logic [31:0] stage_val(input int k, input int c);
      if (k == 0) return (c == 2) ? pc_4_exe : alu_out_exe;
      if (k == 1) return (c == 2) ? pc_4_acc : ((c == 3) ? dmem_out_acc : alu_out_acc);
      return wb_data;
   endfunction

   // Youngest writer of the source wins; a load that is not ready yet asks for a stall of n cycles.
   function automatic void resolve(input int src, input int lat, output logic [1:0] sel,
                                   output logic [31:0] data, output int n);
      logic [6:0]  op;
      logic [4:0]  rs;
      logic        used;
      logic [31:0] st_i [3];
      logic        st_v [3];
      op   = instr_de[6:0];
      rs   = (src == 1) ? instr_de[19:15] : instr_de[24:20];
      used = (src == 1) ? !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL)
                        : (op == OP_OP || op == OP_STORE || op == OP_BRANCH);
      sel  = 2'd0;
      data = (src == 1) ? rs1_data_de : rs2_data_de;
      n    = 0;
      st_i = '{instr_exe, instr_acc, instr_wb};
      st_v = '{valid_exe, valid_acc, valid_wb};
      if (!used || rs == 5'd0) return;
      for (int k = 0; k < 3; k++) begin
         int c;
         c = cls(st_i[k][6:0]);
         if (st_v[k] && c != 0 && st_i[k][11:7] == rs) begin
            sel  = 2'(k + 1);
            data = stage_val(k, c);
            if (c == 3) begin
               if (k == 0) n = lat;
               else if (k == 1 && lat == 2) n = 1;
            end
            return;
         end
      end
   endfunction

   function automatic exp_t predict(input int lat, inout int left);
      exp_t        e;
      logic [1:0]  sa, sb;
      logic [31:0] da, db;
      int          na, nb, n;
      resolve(1, lat, sa, da, na);
      resolve(2, lat, sb, db, nb);
      n = (na > nb) ? na : nb;
      if (rst || flush) begin
         e.stall = 1'b0;
         left    = 0;
      end else if (left > 0) begin
         e.stall = 1'b1;
         left    = left - 1;
      end else if (n > 0) begin
         e.stall = 1'b1;
         left    = n - 1;
      end else begin
         e.stall = 1'b0;
      end
      e.chk    = !e.stall;
      e.hazard = (sa != 2'd0) || (sb != 2'd0);
      e.sa = sa; e.sb = sb; e.da = da; e.db = db;
      return e;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic check_dut(input string tag, input exp_t e, input logic stall, input logic hazard,
                            input logic [1:0] sa, input logic [1:0] sb,
                            input logic [31:0] da, input logic [31:0] db);
      cmp({tag, ".stall"}, 32'(stall), 32'(e.stall));
      if (e.chk) begin
         cmp({tag, ".hazard"}, 32'(hazard), 32'(e.hazard));
         cmp({tag, ".fwd_sel_a"}, 32'(sa), 32'(e.sa));
         cmp({tag, ".fwd_sel_b"}, 32'(sb), 32'(e.sb));
         cmp({tag, ".data_a"}, da, e.da);
         cmp({tag, ".data_b"}, db, e.db);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check_dut("lat1", e, h1.stall, h1.hazard, h1.fwd_sel_a, h1.fwd_sel_b,
                   h1.data_a_mgr, h1.data_b_mgr);
      end
      if (q2.size() > 0) begin
         e = q2.pop_front();
         check_dut("lat2", e, h2.stall, h2.hazard, h2.fwd_sel_a, h2.fwd_sel_b,
                   h2.data_a_mgr, h2.data_b_mgr);
      end
   end

   task automatic apply();
      q1.push_back(predict(1, left1));
      q2.push_back(predict(2, left2));
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      flush = 1'b0;
      instr_de = mk(OP_OPIMM, 5'd0, 5'd0, 5'd0);
      instr_exe = instr_de; instr_acc = instr_de; instr_wb = instr_de;
      valid_exe = 1'b0; valid_acc = 1'b0; valid_wb = 1'b0;
      rs1_data_de = $urandom(); rs2_data_de = $urandom();
      alu_out_exe = $urandom(); pc_4_exe = $urandom();
      alu_out_acc = $urandom(); pc_4_acc = $urandom();
      dmem_out_acc = $urandom(); wb_data = $urandom();
   endtask

   function automatic logic [31:0] rnd_instr();
      logic [31:0] r;
      r = $urandom();
      return {r[31:25], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), r[14:12],
              5'($urandom_range(0, 3)), ops[$urandom_range(0, 9)]};
   endfunction

   initial begin
      ops = '{OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP, OP_JAL, OP_JALR, OP_LOAD, OP_STORE, OP_BRANCH, OP_SYS};
      rst = 1'b1;
      clr();
      next(); apply();
      next(); rst = 1'b0; clr(); apply();

      // EXE ALU producer feeds rs1
      next(); clr();
      instr_exe = mk(OP_OP, 5'd5, 5'd1, 5'd2); valid_exe = 1'b1; alu_out_exe = 32'h1234;
      instr_de = mk(OP_OP, 5'd6, 5'd5, 5'd7); apply();

      // EXE beats ACC for both operands
      next(); clr();
      instr_exe = mk(OP_OPIMM, 5'd3, 5'd0, 5'd0); valid_exe = 1'b1; alu_out_exe = 32'hA;
      instr_acc = mk(OP_OPIMM, 5'd3, 5'd0, 5'd0); valid_acc = 1'b1; alu_out_acc = 32'hB;
      instr_de = mk(OP_OP, 5'd1, 5'd3, 5'd3); apply();

      // load-use walking through EXE, ACC, WB
      next(); clr();
      instr_exe = mk(OP_LOAD, 5'd4, 5'd2, 5'd0); valid_exe = 1'b1;
      instr_de = mk(OP_OP, 5'd1, 5'd4, 5'd0); apply();
      next(); valid_exe = 1'b0;
      instr_acc = mk(OP_LOAD, 5'd4, 5'd2, 5'd0); valid_acc = 1'b1; dmem_out_acc = 32'hBEEF; apply();
      next(); valid_acc = 1'b0;
      instr_wb = mk(OP_LOAD, 5'd4, 5'd2, 5'd0); valid_wb = 1'b1; wb_data = 32'hC0FFEE; apply();

      // flush in the first stall cycle
      next(); clr();
      instr_exe = mk(OP_LOAD, 5'd4, 5'd2, 5'd0); valid_exe = 1'b1;
      instr_de = mk(OP_OP, 5'd1, 5'd4, 5'd0); flush = 1'b1; apply();
      next(); clr(); instr_de = mk(OP_OP, 5'd1, 5'd4, 5'd0); apply();

      // reset raised mid-cycle while the LOAD_LAT=2 unit is stalling
      next(); clr();
      instr_exe = mk(OP_LOAD, 5'd4, 5'd2, 5'd0); valid_exe = 1'b1;
      instr_de = mk(OP_OP, 5'd1, 5'd4, 5'd0); apply();
      next(); valid_exe = 1'b0;
      instr_acc = mk(OP_LOAD, 5'd4, 5'd2, 5'd0); valid_acc = 1'b1; rst = 1'b1; apply();
      next(); rst = 1'b0; clr(); apply();

      // x0 never forwarded; STORE is not a producer
      next(); clr();
      instr_exe = mk(OP_OP, 5'd0, 5'd1, 5'd2); valid_exe = 1'b1;
      instr_de = mk(OP_OP, 5'd1, 5'd0, 5'd0); apply();
      next(); clr();
      instr_exe = mk(OP_STORE, 5'd5, 5'd1, 5'd2); valid_exe = 1'b1;
      instr_de = mk(OP_OP, 5'd1, 5'd5, 5'd5); apply();

      for (int i = 0; i < 3000; i++) begin
         next();
         rst = ($urandom_range(0, 499) == 0);
         flush = ($urandom_range(0, 11) == 0);
         instr_de = rnd_instr(); instr_exe = rnd_instr();
         instr_acc = rnd_instr(); instr_wb = rnd_instr();
         valid_exe = ($urandom_range(0, 3) != 0);
         valid_acc = ($urandom_range(0, 3) != 0);
         valid_wb = ($urandom_range(0, 3) != 0);
         rs1_data_de = $urandom(); rs2_data_de = $urandom();
         alu_out_exe = $urandom(); pc_4_exe = $urandom();
         alu_out_acc = $urandom(); pc_4_acc = $urandom();
         dmem_out_acc = $urandom(); wb_data = $urandom();
         apply();
      end

      next(); rst = 1'b0; clr();
      next(); next();
      cmp("scoreboard_drained", 32'(q1.size() + q2.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
